seg7_scan_driver: RTL and testbench

//   Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits.

---
 rtl/seg7_scan_driver_if.sv | 28 ++
 rtl/seg7_scan_driver.sv | 108 ++++++++++
 tb/tb_seg7_scan_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Host/board-side signal bundle for the multiplexed 7-segment scan driver.
// master drives the register-file and display controls; slave is the driver itself.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
) ();
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [IDX_W-1:0]      wr_addr;
  logic [3:0]            wr_data;
  logic                  clear;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  lz_blank;
  logic [6:0]            segments;
  logic                  dp;
  logic [NUM_DIGITS-1:0] anode;

  modport master (
    output wr_en, wr_addr, wr_data, clear, digit_en, dp_in, lz_blank,
    input  segments, dp, anode
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clear, digit_en, dp_in, lz_blank,
    output segments, dp, anode
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: nibble register file, refresh prescaler,
// hex decode, per-digit enable/decimal point and leading-zero blanking; all outputs registered.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PRE_W-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic [NUM_DIGITS-1:0]      anode_q, anode_d;
  logic [NUM_DIGITS-1:0]      lead_zero;
  logic                       zero_run;
  logic                       dark;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Refresh prescaler and scan index
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Register file; out-of-range addresses match no digit, clear overrides a write
  always_comb begin
    digit_d = digit_q;
    if (bus.clear) begin
      digit_d = '0;
    end else if (bus.wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.wr_addr == IDX_W'(i)) digit_d[i] = bus.wr_data;
      end
    end
  end

  // lead_zero[i] is set when digit i and every digit above it hold zero
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    dark      = 1'b1;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    anode_d   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (digit_q[i] == 4'h0);
      lead_zero[i] = zero_run;
    end
    dark = ~bus.digit_en[idx_q] | (bus.lz_blank & (idx_q != '0) & lead_zero[idx_q]);
    if (!dark) begin
      anode_d[idx_q] = 1'b0;
      seg_d          = decode(digit_q[idx_q]);
      dp_d           = ~bus.dp_in[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      digit_q <= '0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      anode_q <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      anode_q <= anode_d;
    end
  end

  assign bus.segments = seg_q;
  assign bus.dp       = dp_q;
  assign bus.anode    = anode_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: directed stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares; a second 5-digit instance covers out-of-range writes.
module tb_seg7_scan_driver;
  typedef struct {
    int         at;
    int         sel;
    logic [7:0] an;
    logic [6:0] sg;
    logic       dp;
    string      nm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n0 = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver_if #(.NUM_DIGITS(4)) if4 ();
  seg7_scan_driver_if #(.NUM_DIGITS(5)) if5 ();

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  seg7_scan_driver #(.NUM_DIGITS(5), .REFRESH_DIV(2)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: anode one-hot-or-none every cycle, plus scheduled scoreboard entries
  always @(negedge clk) begin
    logic [7:0] act_an;
    logic [6:0] act_sg;
    logic       act_dp;
    if (cyc > 0) begin
      n_checks++;
      if ($countones(~if4.anode) > 1) begin
        n_fail++;
        $display("FAIL onehot4 cyc=%0d anode=%b required at most one low", cyc, if4.anode);
      end
      n_checks++;
      if ($countones(~if5.anode) > 1) begin
        n_fail++;
        $display("FAIL onehot5 cyc=%0d anode=%b required at most one low", cyc, if5.anode);
      end
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.at < cyc) begin
        n_fail++;
        $display("FAIL %s stale entry at=%0d now=%0d", e.nm, e.at, cyc);
      end else begin
        act_an = (e.sel == 0) ? {4'hF, if4.anode} : {3'h7, if5.anode};
        act_sg = (e.sel == 0) ? if4.segments : if5.segments;
        act_dp = (e.sel == 0) ? if4.dp : if5.dp;
        if (act_an !== e.an || act_sg !== e.sg || act_dp !== e.dp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                   e.nm, cyc, act_an, act_sg, act_dp, e.an, e.sg, e.dp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input int at, input int sel, input logic [7:0] an, input logic [6:0] sg,
                      input logic dp, input string nm);
    exp_t x;
    x.at  = at;
    x.sel = sel;
    x.an  = an;
    x.sg  = sg;
    x.dp  = dp;
    x.nm  = nm;
    sb.push_back(x);
  endtask

  // Expected outputs for cycles n0+first_r .. ; slot shown after edge n0+r is ((r-1)/div)%nd
  task automatic push_window(input int sel, input int first_r, input int cnt, input int div,
                             input int nd, input logic [34:0] seg_tab, input logic [4:0] lit,
                             input logic [4:0] dpv, input string nm);
    for (int r = first_r; r < first_r + cnt; r++) begin
      int s;
      logic [7:0] an;
      s  = ((r - 1) / div) % nd;
      an = 8'hFF;
      if (lit[s]) an[s] = 1'b0;
      push(n0 + r, sel, an, lit[s] ? seg_tab[s*7 +: 7] : 7'h7F, lit[s] ? dpv[s] : 1'b1, nm);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push(cyc + 1, 0, 8'hFF, 7'h7F, 1'b1, "mid_reset");
    tick();
    tick();
    rst = 1'b0;
    n0  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst          = 1'b1;
    if4.wr_en    = 1'b0;
    if4.wr_addr  = '0;
    if4.wr_data  = '0;
    if4.clear    = 1'b0;
    if4.digit_en = 4'hF;
    if4.dp_in    = 4'h0;
    if4.lz_blank = 1'b0;
    if5.wr_en    = 1'b0;
    if5.wr_addr  = '0;
    if5.wr_data  = '0;
    if5.clear    = 1'b0;
    if5.digit_en = 5'h1F;
    if5.dp_in    = 5'h00;
    if5.lz_blank = 1'b0;

    // Reset held three cycles, then first lit digit 0
    for (int c = 1; c <= 3; c++) push(c, 0, 8'hFF, 7'h7F, 1'b1, "reset_hold");
    wait_until(3);
    rst = 1'b0;
    n0  = cyc;
    push_window(0, 1, 8, 4, 4, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b01111, 5'b11111,
                "first_lit");
    wait_until(n0 + 8);

    // All 16 decodes written to digit 0 while it is scanned
    do_reset();
    for (int v = 0; v < 16; v++) begin
      k = n0 + 16 * (v / 4 + 1) + (v % 4);
      wait_until(k - 1);
      if4.wr_en   = 1'b1;
      if4.wr_addr = 2'd0;
      if4.wr_data = 4'(v);
      push(k + 1, 0, 8'hFE, dec_tab[v], 1'b1, "decode");
      tick();
      if4.wr_en = 1'b0;
    end

    // Free-run scan: digit 0 = F, others 0
    push_window(0, 81, 40, 4, 4, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h0E}, 5'b01111, 5'b11111,
                "free_run");
    wait_until(n0 + 120);

    // Leading-zero blanking with digits {0,0,3,0}, then all zero
    do_reset();
    if4.lz_blank = 1'b1;
    if4.dp_in    = 4'b1000;
    if4.wr_en    = 1'b1;
    if4.wr_addr  = 2'd2;
    if4.wr_data  = 4'd3;
    tick();
    if4.wr_en = 1'b0;
    push_window(0, 17, 16, 4, 4, {7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40}, 5'b00111, 5'b11111,
                "lz_blank");
    wait_until(n0 + 32);
    if4.clear = 1'b1;
    if4.dp_in = 4'b0000;
    tick();
    if4.clear = 1'b0;
    push_window(0, 49, 16, 4, 4, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 5'b00001, 5'b11111,
                "lz_all_zero");
    wait_until(n0 + 64);

    // Clear beats simultaneous write; out-of-range addresses ignored on the 5-digit unit
    do_reset();
    if4.lz_blank = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if4.wr_en   = 1'b1;
      if4.wr_addr = 2'(i);
      if4.wr_data = 4'(i + 1);
      if5.wr_en   = 1'b1;
      if5.wr_addr = (i < 3) ? 3'(5 + i) : 3'd4;
      if5.wr_data = (i < 3) ? 4'd9 : 4'd2;
      tick();
    end
    if5.wr_en   = 1'b0;
    if4.clear   = 1'b1;
    if4.wr_en   = 1'b1;
    if4.wr_addr = 2'd2;
    if4.wr_data = 4'd7;
    tick();
    if4.clear = 1'b0;
    if4.wr_en = 1'b0;
    push_window(1, 21, 10, 2, 5, {7'h24, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b11111, 5'b11111,
                "addr_range");
    push_window(0, 33, 16, 4, 4, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40}, 5'b01111, 5'b11111,
                "clear_wins");
    wait_until(n0 + 48);

    // Disabled digit 2 stays dark with its dp; then a lit dp on digit 1
    do_reset();
    if4.digit_en = 4'b1011;
    if4.dp_in    = 4'b0100;
    push_window(0, 17, 16, 4, 4, {7'h7F, 7'h40, 7'h7F, 7'h40, 7'h40}, 5'b01011, 5'b11111,
                "digit_en");
    wait_until(n0 + 32);
    if4.dp_in = 4'b0110;
    push_window(0, 33, 16, 4, 4, {7'h7F, 7'h40, 7'h7F, 7'h40, 7'h40}, 5'b01011, 5'b11101,
                "dp_lit");
    wait_until(n0 + 50);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
